// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the instruction/data memory arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;
  localparam int STARVE_CNT_W = 4;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch port, load/store port and memory port bundled for the arbiter
// Ports: slave = arbiter view (requests and mem_rdata in; grants, responses and memory strobes out),
//        master = core/memory view (the mirror image).
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 10
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic [3:0]        d_be;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic [31:0]       mem_rdata;
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between instruction fetch and load/store
// Ports: clk, reset (sync, active-high); bus (mem_arbiter_if.slave) carrying both requester ports and the memory port.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int MEM_AW     = 10,
  parameter int STARVE_MAX = 4
) (
  input logic           clk,
  input logic           reset,
  mem_arbiter_if.slave  bus
);
  localparam logic [STARVE_CNT_W-1:0] SMAX = STARVE_CNT_W'(STARVE_MAX);
  logic [STARVE_CNT_W-1:0] starve_cnt;
  owner_t                  rd_owner;
  logic                    if_win;
  logic                    unused_addr;
  // Data wins collisions unless fetch has been denied STARVE_MAX times in a row.
  assign if_win = bus.if_req && (!bus.d_req || starve_cnt == SMAX);
  assign bus.if_gnt = !reset && if_win;
  assign bus.d_gnt  = !reset && bus.d_req && !if_win;
  assign bus.mem_en    = bus.if_gnt || bus.d_gnt;
  assign bus.mem_we    = bus.d_gnt && bus.d_we;
  assign bus.mem_addr  = bus.if_gnt ? bus.if_addr[MEM_AW+1:2] : bus.d_gnt ? bus.d_addr[MEM_AW+1:2] : '0;
  assign bus.mem_wdata = bus.d_gnt ? bus.d_wdata : '0;
  assign bus.mem_be    = bus.if_gnt ? 4'hF : bus.d_gnt ? bus.d_be : 4'h0;
  // Valids are suppressed during reset so an in-flight read is dropped immediately.
  assign bus.if_rvalid = !reset && rd_owner == OWN_IF;
  assign bus.d_rvalid  = !reset && rd_owner == OWN_D;
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;
  assign unused_addr = ^{bus.if_addr[ADDR_W-1:MEM_AW+2], bus.if_addr[1:0],
                         bus.d_addr[ADDR_W-1:MEM_AW+2], bus.d_addr[1:0]};
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
      rd_owner   <= OWN_NONE;
    end else begin
      starve_cnt <= (!bus.if_req || bus.if_gnt) ? '0 : (starve_cnt == SMAX) ? starve_cnt : starve_cnt + 1'b1;
      rd_owner   <= bus.if_gnt ? OWN_IF : (bus.d_gnt && !bus.d_we) ? OWN_D : OWN_NONE;
    end
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port unified instruction/data memory between the CPU's instruction-fetch port and its load/store port. Every cycle it grants at most one requester, drives the memory port, and routes the one-cycle-latency read data back to the requester that issued the read. Data accesses have priority; a starvation counter guarantees forward progress for fetch. Instantiated inside `top` between the core and the memory.

## Interface
- `ADDR_W`, 32: byte-address width of both requester ports.
- `MEM_AW`, 10: word-address width of the memory, covering 4 KiB.
- `STARVE_MAX`, 4: consecutive fetch denials before fetch is forced to win; legal range 1..15.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `if_req`  in  1  fetch read request.
- `if_addr`  in  ADDR_W  fetch byte address.
- `if_gnt`  out  1  fetch request accepted this cycle.
- `if_rvalid`  out  1  `if_rdata` valid.
- `if_rdata`  out  32  fetch read data.
- `d_req`  in  1  load/store request.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_W  data byte address.
- `d_wdata`  in  32  store data.
- `d_be`  in  4  store byte enables.
- `d_gnt`  out  1  data request accepted this cycle.
- `d_rvalid`  out  1  `d_rdata` valid. Loads only.
- `d_rdata`  out  32  load data.
- `mem_en`, `mem_we`  out  1 each  memory access strobe and write enable.
- `mem_addr`  out  MEM_AW  word address.
- `mem_wdata`  out  32  write data.
- `mem_be`  out  4  byte enables.
- `mem_rdata`  in  32  registered read data, valid the cycle after a read strobe.

## Operation
- **Grant:** combinational from the current requests and the registered state. At most one of `if_gnt` and `d_gnt` is high in any cycle.
- **Priority rule:**
  - Only one requester active: it wins.
  - Both active and `starve_cnt == STARVE_MAX`: fetch wins.
  - Both active otherwise: data wins.
- **Starvation counter `starve_cnt`** (4 bits):
  - `if_req && !if_gnt`: increment, saturating at `STARVE_MAX`.
  - `if_gnt`: clear to 0.
  - `!if_req`: clear to 0.
- **Requester obligation:** hold `req` and all request fields stable until `gnt`. The arbiter does not latch ungranted requests.
- **Memory drive** (from the granted port):
  - `mem_en` = either grant.
  - `mem_addr` = `addr[MEM_AW+1:2]`; low two address bits are ignored.
  - Fetch drives `mem_we = 0` and `mem_be = 4'hF`.
  - With no grant, `mem_we`, `mem_addr`, `mem_wdata` and `mem_be` are 0.
- **Response tag `rd_owner`:** registered, one of NONE/IF/D. Set to the granted reader each cycle; NONE for a store or an idle cycle.
- **Read data routing:**
  - `if_rvalid = (rd_owner == IF)`; `d_rvalid = (rd_owner == D)`.
  - `if_rdata` and `d_rdata` are both `mem_rdata`; only the valids are steered.
- Stores produce no response.

## Timing
- Grant latency: 0 cycles (same cycle as `req`).
- Read latency: `rvalid` is asserted exactly 1 cycle after the grant cycle, for exactly 1 cycle.
- Throughput: one access per cycle. Back-to-back reads from alternating owners return in grant order.
- **Reset values:**
  - `starve_cnt = 0`, `rd_owner = NONE`.
  - Both `rvalid` outputs are 0.
  - While `reset` is high, both grants and `mem_en` are forced to 0.
- **Reset during an outstanding read:** the cycle after reset asserts has `rvalid = 0`. The response is dropped and the requester re-issues.
- **Simultaneous requests:** exactly one winner per the priority rule. The loser sees `gnt = 0` and retries in the next cycle.
- **Store and read in consecutive cycles:** no hazard. The memory handles write-then-read ordering.
- **Sustained data traffic with fetch pending:** fetch is granted no later than the (`STARVE_MAX`+1)-th cycle of its request.

## Structure
- Package `mem_arb_pkg` holds:
  - `typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;`
  - the `STARVE_CNT_W = 4` constant.
- No sub-module; the starvation counter, tag register and grant logic live in `mem_arbiter`.
- `top` instantiates the block; `top_tb` observes it hierarchically.

## Test plan
- **Fetch only:** `if_req = 1`, `if_addr = 0x10` for 3 cycles, with memory word 4 = `0xDEADBEEF` → `if_gnt` high each cycle, `mem_addr = 4`; `if_rvalid` with `0xDEADBEEF` on cycles 2–4; `d_rvalid` stays 0.
- **Store then load:** store `d_addr = 0x20`, `d_wdata = 0x12345678`, `d_be = 4'b0011`, then load `0x20`:
  - store cycle: `mem_we = 1`, `mem_be = 3`, no `rvalid`;
  - load cycle +1: `d_rvalid` with `0x00005678` (word pre-zeroed).
- **Collision:** `if_req` and a `d_req` load in the same cycle → `d_gnt = 1`, `if_gnt = 0`; next cycle `d_rvalid = 1`, `if_rvalid = 0`; fetch is granted once `d_req` drops.
- **Starvation** (`STARVE_MAX = 4`): `d_req` held continuously and `if_req` held → `d_gnt` on cycles 1–4, `if_gnt` on cycle 5, `starve_cnt` back to 0, `d_gnt` on cycle 6.
- **Reset mid-read:** grant a fetch read, assert `reset` in the next cycle → `if_rvalid = 0`, both grants 0, `mem_en = 0` while reset is high; after release, a fresh request completes normally.
